// File: rtl/amber48_uart_tx_fifo_if.sv
// Bus between the CPU-side writer, the TX byte FIFO and the UART transmitter.
// The master drives the write side and the transmitter handshake; the slave is the FIFO.
interface amber48_uart_tx_fifo_if #(
  parameter int unsigned DEPTH = 16
);
  logic [7:0]             wr_data_i;
  logic                   wr_valid_i;
  logic                   wr_ready_o;
  logic                   flush_i;
  logic [7:0]             tx_data_o;
  logic                   tx_valid_o;
  logic                   tx_ready_i;
  logic [$clog2(DEPTH):0] level_o;
  logic                   empty_o;
  logic                   full_o;
  logic                   afull_o;
  logic                   overflow_o;
  logic                   ovf_clr_i;

  modport slave (
    input  wr_data_i, wr_valid_i, flush_i, tx_ready_i, ovf_clr_i,
    output wr_ready_o, tx_data_o, tx_valid_o, level_o, empty_o, full_o,
           afull_o, overflow_o
  );

  modport master (
    output wr_data_i, wr_valid_i, flush_i, tx_ready_i, ovf_clr_i,
    input  wr_ready_o, tx_data_o, tx_valid_o, level_o, empty_o, full_o,
           afull_o, overflow_o
  );
endinterface

// File: rtl/amber48_uart_tx_fifo.sv
// Byte FIFO feeding amber48_uart_tx: valid/ready on both sides, level and
// empty/full/almost-full status, sticky overflow flag.
module amber48_uart_tx_fifo #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned AFULL_LEVEL = 12
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  amber48_uart_tx_fifo_if.slave         bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] LP_DEPTH = PW'(DEPTH);
  localparam logic [PW-1:0] LP_AFULL = PW'(AFULL_LEVEL);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $fatal(1, "amber48_uart_tx_fifo: DEPTH must be a power of 2 and >= 2");
  end
  if ((AFULL_LEVEL < 1) || (AFULL_LEVEL > DEPTH)) begin : g_bad_afull
    $fatal(1, "amber48_uart_tx_fifo: AFULL_LEVEL must be in 1..DEPTH");
  end

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_ovf_dummy_unused;
  logic          r_overflow;

  logic [PW-1:0] w_level;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_rd_idx;
  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;

  // Extra MSB on each pointer distinguishes full from empty; the difference
  // wraps cleanly mod 2*DEPTH and is the level directly.
  always_comb begin
    w_level  = r_wr_ptr - r_rd_ptr;
    w_wr_idx = r_wr_ptr[AW-1:0];
    w_rd_idx = r_rd_ptr[AW-1:0];
    w_empty  = (w_level == '0);
    w_full   = (w_level == LP_DEPTH);
    w_push   = bus.wr_valid_i & ~w_full;
    w_pop    = ~w_empty & bus.tx_ready_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else if (bus.flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (bus.wr_valid_i && w_full) r_overflow <= 1'b1;
      else if (bus.ovf_clr_i)      r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    r_ovf_dummy_unused <= '0;
    if (!rst_i && !bus.flush_i && w_push) r_mem[w_wr_idx] <= bus.wr_data_i;
  end

  // Head byte is forced to zero when empty so the UART never sees X.
  always_comb begin
    bus.tx_data_o  = w_empty ? 8'h00 : r_mem[w_rd_idx];
    bus.tx_valid_o = ~w_empty;
    bus.wr_ready_o = ~w_full;
    bus.level_o    = w_level;
    bus.empty_o    = w_empty;
    bus.full_o     = w_full;
    bus.afull_o    = (w_level >= LP_AFULL);
    bus.overflow_o = r_overflow;
  end
endmodule
